// File: rtl/mem_access_ctrl_pkg.sv
// Shared ARM pipeline definitions for the data-memory access controller:
// FSM state encoding, request bundle and the default data-memory base.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } mac_state_t;

   typedef struct packed {
      logic rd;
      logic wr;
   } mem_req_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/mem_access_ctrl_phase_counter.sv
// Phase counter for the SRAM controller: cleared on state change,
// counts cycles spent inside the LO and HI phases.
module mem_access_ctrl_phase_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc) cnt <= cnt + 4'd1;
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM phases (LO then HI),
// stalling the pipeline with ready = 0 until the access completes.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic [31:0] alu_res,
   input  logic [31:0] val_Rm,
   output logic        ready,
   output logic [31:0] read_data,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   mac_state_t  state, state_nxt;
   mem_req_t    req;
   logic        req_any;
   logic        op_wr;
   logic [3:0]  cnt;
   logic        in_phase;
   logic        last;
   logic [31:0] addr_off;
   logic [16:0] word;
   logic        addr_unused;

   assign req         = '{rd: mem_read_en, wr: mem_write_en};
   assign req_any     = req.rd | req.wr;
   assign in_phase    = (state == LO) || (state == HI);
   assign last        = (cnt == LAST_CNT);

   // Inputs are held stable by the stalled pipeline, so the address is not registered.
   assign addr_off    = alu_res - BASE_ADDR;
   assign word        = addr_off[18:2];
   assign addr_unused = ^{addr_off[31:19], addr_off[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Write wins when both enables are raised together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        op_wr <= 1'b0;
      else if (state == IDLE && req_any) op_wr <= req.wr;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = LO;
         LO:      if (last)    state_nxt = HI;
         HI:      if (last)    state_nxt = DONE;
         DONE:                 state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   mem_access_ctrl_phase_counter u_phase_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nxt != state),
      .inc   (in_phase),
      .cnt   (cnt)
   );

   always_comb begin
      ready       = 1'b1;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      case (state)
         IDLE:    ready = ~req_any;
         LO: begin
            ready     = 1'b0;
            sram_addr = {word, 1'b0};
         end
         HI: begin
            ready     = 1'b0;
            sram_addr = {word, 1'b1};
         end
         default: ready = 1'b1;
      endcase
      // Strobe drops on the last cycle of each phase so address and data hold past it.
      if (in_phase && op_wr) begin
         sram_dq_oe  = 1'b1;
         sram_we_n   = last;
         sram_dq_out = (state == HI) ? val_Rm[31:16] : val_Rm[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data <= '0;
      end else if (!op_wr && last) begin
         if (state == LO) read_data[15:0]  <= sram_dq_in;
         if (state == HI) read_data[31:16] <= sram_dq_in;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: asynchronous SRAM model plus a
// transaction-level reference of the expected timing and memory contents.
module tb_mem_access_ctrl;

   localparam int          W    = 3;
   localparam logic [31:0] BASE = 32'd1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read_en = 1'b0;
   logic        mem_write_en = 1'b0;
   logic [31:0] alu_res = '0;
   logic [31:0] val_Rm = '0;
   logic        ready;
   logic [31:0] read_data;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   int checks = 0;
   int failures = 0;

   logic [15:0] sram_mem [0:1023];
   logic [15:0] exp_mem  [0:1023];
   logic [31:0] exp_rd = '0;
   int          written[$];

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .alu_res      (alu_res),
      .val_Rm       (val_Rm),
      .ready        (ready),
      .read_data    (read_data),
      .sram_addr    (sram_addr),
      .sram_dq_out  (sram_dq_out),
      .sram_dq_oe   (sram_dq_oe),
      .sram_dq_in   (sram_dq_in),
      .sram_we_n    (sram_we_n)
   );

   assign sram_dq_in = sram_mem[sram_addr[9:0]];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[9:0]] <= sram_dq_out;

   // One full access starting in an IDLE cycle; the reference derives each
   // cycle's expected bus from its position in the 1 + W + W + 1 sequence.
   task automatic run_access(input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] a;
      logic [16:0] w;
      logic [17:0] ea;
      logic [15:0] edq;
      bit          erdy, ewe, eoe, hi;
      int          j, lows;
      a = adr - BASE;
      w = a[18:2];
      mem_read_en = rd; mem_write_en = wr; alu_res = adr; val_Rm = dat;
      lows = 0;
      for (int k = 0; k <= 2*W+1; k++) begin
         @(negedge clk);
         erdy = (k == 2*W+1); ea = '0; ewe = 1'b1; eoe = 1'b0; edq = '0;
         if (k >= 1 && k <= 2*W) begin
            hi = (k > W);
            j  = hi ? k - W - 1 : k - 1;
            ea = {w, hi};
            if (wr) begin
               eoe = 1'b1;
               ewe = (j == W - 1);
               edq = hi ? dat[31:16] : dat[15:0];
            end
         end
         if (!ready) lows++;
         checks++;
         if ({ready, sram_addr, sram_we_n, sram_dq_oe} !== {erdy, ea, ewe, eoe}) begin
            failures++;
            $display("FAIL access_cycle%0d adr=%h: got rdy=%b addr=%h we_n=%b oe=%b want rdy=%b addr=%h we_n=%b oe=%b",
                     k, adr, ready, sram_addr, sram_we_n, sram_dq_oe, erdy, ea, ewe, eoe);
         end
         if (eoe) begin
            checks++;
            if (sram_dq_out !== edq) begin
               failures++;
               $display("FAIL dq_out_cycle%0d: got %h want %h", k, sram_dq_out, edq);
            end
         end
         if (k == 2*W+1) begin
            if (rd && !wr) exp_rd = {exp_mem[{w[8:0], 1'b1}], exp_mem[{w[8:0], 1'b0}]};
            checks++;
            if (read_data !== exp_rd) begin
               failures++;
               $display("FAIL read_data_done adr=%h: got %h want %h", adr, read_data, exp_rd);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (lows != 2*W+1) begin
         failures++;
         $display("FAIL freeze_len: got %0d want %0d", lows, 2*W+1);
      end
      if (wr) begin
         exp_mem[{w[8:0], 1'b0}] = dat[15:0];
         exp_mem[{w[8:0], 1'b1}] = dat[31:16];
         written.push_back(int'(w));
      end
      mem_read_en = 1'b0; mem_write_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({ready, sram_we_n, sram_dq_oe, sram_addr, read_data} !== {1'b1, 1'b1, 1'b0, 18'd0, 32'd0}) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b we_n=%b oe=%b addr=%h rd=%h want 1 1 0 0 0",
                  ready, sram_we_n, sram_dq_oe, sram_addr, read_data);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_no_request();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({ready, sram_we_n, sram_dq_oe, sram_addr} !== {1'b1, 1'b1, 1'b0, 18'd0}) begin
            failures++;
            $display("FAIL no_request_cycle%0d: got rdy=%b we_n=%b oe=%b addr=%h", i, ready, sram_we_n, sram_dq_oe, sram_addr);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
      checks++;
      if (sram_mem[2] !== 16'hBEEF || sram_mem[3] !== 16'hDEAD) begin
         failures++;
         $display("FAIL store_mem: got [2]=%h [3]=%h want BEEF DEAD", sram_mem[2], sram_mem[3]);
      end
   endtask

   task automatic test_load();
      run_access(1'b1, 1'b0, 32'd1028, $urandom);
      checks++;
      if (read_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL load_value: got %h want deadbeef", read_data);
      end
   endtask

   task automatic test_simultaneous();
      run_access(1'b1, 1'b1, 32'd1032, 32'h12345678);
      checks++;
      if (read_data !== 32'hDEADBEEF || sram_mem[4] !== 16'h5678 || sram_mem[5] !== 16'h1234) begin
         failures++;
         $display("FAIL simultaneous: got rd=%h [4]=%h [5]=%h want deadbeef 5678 1234", read_data, sram_mem[4], sram_mem[5]);
      end
   endtask

   task automatic test_back_to_back();
      run_access(1'b1, 1'b0, 32'd1032, 32'h0);
      run_access(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
      run_access(1'b1, 1'b0, 32'd1037, 32'h0);
      checks++;
      if (read_data !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL back_to_back_load: got %h want cafef00d", read_data);
      end
   endtask

   task automatic test_reset_abort();
      alu_res = BASE + 32'd400; val_Rm = 32'hA5A55A5A; mem_write_en = 1'b1;
      repeat (W + 2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (sram_we_n !== 1'b0) begin
         failures++;
         $display("FAIL abort_precondition: got we_n=%b want 0", sram_we_n);
      end
      rst_n = 1'b0; mem_write_en = 1'b0;
      #1;
      checks++;
      if ({ready, sram_we_n, sram_dq_oe, sram_addr, read_data} !== {1'b1, 1'b1, 1'b0, 18'd0, 32'd0}) begin
         failures++;
         $display("FAIL abort_immediate: got rdy=%b we_n=%b oe=%b addr=%h rd=%h", ready, sram_we_n, sram_dq_oe, sram_addr, read_data);
      end
      #1 rst_n = 1'b1;
      exp_rd = '0;
      @(posedge clk); #1;
      checks++;
      if ({ready, sram_we_n, sram_dq_oe} !== {1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL abort_after: got rdy=%b we_n=%b oe=%b", ready, sram_we_n, sram_dq_oe);
      end
      run_access(1'b1, 1'b0, 32'd1028, 32'h0);
   endtask

   task automatic test_random();
      int          op, gap, widx;
      logic [31:0] adr;
      for (int n = 0; n < 40; n++) begin
         op  = $urandom_range(0, 2);
         gap = $urandom_range(0, 2);
         if (op == 0 && written.size() > 0) begin
            widx = written[$urandom_range(0, written.size() - 1)];
            adr  = BASE + 32'(widx * 4) + 32'($urandom_range(0, 3));
            run_access(1'b1, 1'b0, adr, $urandom);
         end else begin
            adr = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            run_access(op == 2, 1'b1, adr, $urandom);
         end
         repeat (gap) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
               failures++;
               $display("FAIL random_gap: got rdy=%b we_n=%b want 1 1", ready, sram_we_n);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_no_request();
      test_store();
      test_load();
      test_simultaneous();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: WAIT_CYCLES, default 3, SRAM cycles held per halfword phase (legal range 1..15); BASE_ADDR, default 32'd1024, data-memory base subtracted from the address.
REQ-002 Port clk, input, 1, single rising-edge clock.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port mem_read_en, input, 1, load request from the EXE pipeline register.
REQ-005 Port mem_write_en, input, 1, store request from the EXE pipeline register.
REQ-006 Port alu_res, input, 32, byte address of the load or store.
REQ-007 Port val_Rm, input, 32, store data.
REQ-008 Port ready, output, 1, 0 = freeze all pipeline registers and PC.
REQ-009 Port read_data, output, 32, load result.
REQ-010 Port sram_addr, output, 18, SRAM halfword address.
REQ-011 Port sram_dq_out, output, 16, write data driven to SRAM.
REQ-012 Port sram_dq_oe, output, 1, 1 = controller drives the SRAM DQ bus.
REQ-013 Port sram_dq_in, input, 16, read data from SRAM.
REQ-014 Port sram_we_n, output, 1, active-low SRAM write strobe.

Function
REQ-015 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-016 IDLE SHALL transition to LO when mem_read_en or mem_write_en is 1, and otherwise stay in IDLE.
REQ-017 LO SHALL transition to HI after WAIT_CYCLES cycles; HI SHALL transition to DONE after WAIT_CYCLES cycles; DONE SHALL transition to IDLE unconditionally.
REQ-018 Operation type SHALL be latched on the IDLE->LO transition; when both enables are 1, write SHALL win.
REQ-019 Phase counter SHALL be 4 bits; it SHALL clear on every state change and increment each cycle inside LO and HI.
REQ-020 ready SHALL be combinational: 0 in IDLE with a request pending, 0 in LO, 0 in HI, 1 in DONE, 1 in IDLE with no request.
REQ-021 A request SHALL therefore see ready = 0 for exactly 1 + 2*WAIT_CYCLES cycles, followed by one cycle of ready = 1.
REQ-022 The upstream pipeline SHALL hold its inputs stable while ready = 0, so the controller does not register alu_res or val_Rm.
REQ-023 Address arithmetic: a = alu_res - BASE_ADDR (32-bit, wrap ignored); word index w = a[18:2]; a[1:0] ignored.
REQ-024 sram_addr SHALL be {w,1'b0} in LO and {w,1'b1} in HI, and 18'd0 otherwise.
REQ-025 Write phases: sram_dq_oe = 1 in LO and HI; sram_dq_out = val_Rm[15:0] in LO and val_Rm[31:16] in HI.
REQ-026 Write strobe: sram_we_n = 0 during every cycle of LO and HI except the last cycle of each phase (address/data hold), and 1 at all other times.
REQ-027 Read phases: sram_dq_oe = 0 and sram_we_n = 1 throughout.
REQ-028 Read capture: on the last cycle of LO, sram_dq_in SHALL be registered into read_data[15:0]; on the last cycle of HI, into read_data[31:16].
REQ-029 read_data SHALL hold its value until the next read overwrites it, and writes SHALL leave it unchanged.
REQ-030 Back-to-back accesses: after DONE, the cycle in IDLE samples the next instruction's enables; the same request SHALL never be restarted.
REQ-031 With WAIT_CYCLES = 1, the write strobe SHALL never assert (no-wait SRAM not supported); the bench runs only WAIT_CYCLES >= 2.

Reset
REQ-032 rst_n = 0 SHALL asynchronously force: state IDLE, counter 0, read_data 0, sram_we_n 1, sram_dq_oe 0.
REQ-033 Reset during LO or HI SHALL abort the access immediately, leaving a possibly partial SRAM write.
REQ-034 After rst_n rises, ready SHALL follow REQ-020 in IDLE.

Structure
REQ-035 State encoding (2-bit typedef) and BASE_ADDR default SHALL reside in the shared ARM pipeline package.
REQ-036 No sub-module is required; an optional phase_counter sub-module is permitted.

Verification
REQ-037 Store: WAIT_CYCLES = 3, mem_write_en = 1, alu_res = 1028, val_Rm = 0xDEADBEEF -> SRAM model holds addr 2 = 0xBEEF and addr 3 = 0xDEAD; ready low for 7 cycles, then high for 1.
REQ-038 Load: after the REQ-037 store, mem_read_en = 1, alu_res = 1028 -> read_data = 0xDEADBEEF in the DONE cycle.
REQ-039 Simultaneous enables: mem_read_en = mem_write_en = 1, alu_res = 1032, val_Rm = 0x12345678 -> write performed to addrs 4/5, and read_data unchanged.
REQ-040 Back-to-back: a load then a store with no gap -> two separate 7-cycle freezes separated by exactly one ready = 1 cycle (DONE), then the IDLE evaluation.
REQ-041 Reset abort: rst_n pulsed low in the second cycle of HI -> state IDLE, sram_we_n = 1, sram_dq_oe = 0 within the same cycle, and ready = 1 with no request pending.
REQ-042 No request: enables held 0 for 20 cycles -> ready = 1 constantly, sram_we_n = 1, sram_addr = 0.
